sram_ctrl_512kx8: RTL and testbench

Synchronous single-port controller that turns a clocked request/acknowledge interface into the strobe sequence for the board's 512K x 8 asynchronous SRAM. It sits directly upstream of the SRAM and drives its address, data, chip-enable, read/not-write and output-enable pins. It also guarantees write setup/hold and bus turnaround in whole clock cycles. Clients are the CPU-side bus logic and the testbench transactors.

---
 rtl/sram_ctrl_512kx8.sv | 135 +++++++++++++
 tb/tb_sram_ctrl_512kx8.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_512kx8.sv
// sram_ctrl_512kx8
// Turns a clocked req/ack interface into strobe sequences for a 512K x 8
// asynchronous SRAM. Every SRAM pin, including the data-bus drive enable,
// comes straight from a flop. Strobe widths are whole clock cycles.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req, we, addr, wdata  request; we/addr/wdata latched when accepted (busy=0)
//   busy                high whenever the controller is not idle
//   ack                 one-cycle completion pulse
//   rdata               read data, valid with ack on reads, held until next read
//   sram_addr/_data/_ceb/_rnw/_oeb   SRAM pins (ceb/oeb active low, rnw 1=read)
module sram_ctrl_512kx8 #(
  parameter int unsigned RD_WAIT = 1,  // extra read-strobe cycles, 0..15
  parameter int unsigned WR_WAIT = 1   // extra write-pulse cycles, 0..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [18:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [18:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ceb,
  output logic        sram_rnw,
  output logic        sram_oeb
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_REC, S_WSET, S_WPUL, S_WHOLD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ceb_q, ceb_d;
  logic        rnw_q, rnw_d;
  logic        oeb_q, oeb_d;
  logic        drv_q, drv_d;
  logic        ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          if (we) begin
            state_d = S_WSET;
          end else begin
            state_d = S_RD;
            cnt_d   = 4'(RD_WAIT);
          end
        end
      end
      S_RD: begin
        // Last strobe cycle: the closing edge samples the bus.
        if (cnt_q == 4'd0) begin
          rdata_d = sram_data;
          state_d = S_REC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REC: state_d = S_IDLE;
      S_WSET: begin
        state_d = S_WPUL;
        cnt_d   = 4'(WR_WAIT);
      end
      S_WPUL: begin
        if (cnt_q == 4'd0) state_d = S_WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WHOLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the *next* state and registered, so each
    // pin changes exactly on the edge that enters the state and never
    // depends combinationally on req.
    ceb_d = !(state_d == S_RD || state_d == S_WSET || state_d == S_WPUL);
    rnw_d = (state_d != S_WPUL);
    oeb_d = (state_d != S_RD);
    drv_d = (state_d == S_WSET || state_d == S_WPUL || state_d == S_WHOLD);
    ack_d = (state_d == S_REC || state_d == S_WHOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 19'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      ceb_q   <= 1'b1;
      rnw_q   <= 1'b1;
      oeb_q   <= 1'b1;
      drv_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ceb_q   <= ceb_d;
      rnw_q   <= rnw_d;
      oeb_q   <= oeb_d;
      drv_q   <= drv_d;
      ack_q   <= ack_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_ceb  = ceb_q;
  assign sram_rnw  = rnw_q;
  assign sram_oeb  = oeb_q;
  assign sram_data = drv_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_sram_ctrl_512kx8.sv
// Bench for sram_ctrl_512kx8: two controllers (default waits, and
// RD_WAIT=0/WR_WAIT=3), each attached to a behavioural async SRAM.
// A released bus reads 8'hFF through pullups.
module tb_sram_ctrl_512kx8;
  localparam int RD0 = 1, WR0 = 1;
  localparam int RD1 = 0, WR1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // controller 0
  logic        req0 = 0, we0 = 0;
  logic [18:0] addr0 = 0;
  logic [7:0]  wdata0 = 0;
  logic        busy0, ack0, ceb0, rnw0, oeb0;
  logic [7:0]  rdata0;
  logic [18:0] sa0;
  wire  [7:0]  sd0;
  // controller 1
  logic        req1 = 0, we1 = 0;
  logic [18:0] addr1 = 0;
  logic [7:0]  wdata1 = 0;
  logic        busy1, ack1, ceb1, rnw1, oeb1;
  logic [7:0]  rdata1;
  logic [18:0] sa1;
  wire  [7:0]  sd1;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (sd0[g]);
    pullup (sd1[g]);
  end

  sram_ctrl_512kx8 #(.RD_WAIT(RD0), .WR_WAIT(WR0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .sram_addr(sa0), .sram_data(sd0),
    .sram_ceb(ceb0), .sram_rnw(rnw0), .sram_oeb(oeb0));

  sram_ctrl_512kx8 #(.RD_WAIT(RD1), .WR_WAIT(WR1)) u1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .ack(ack1), .rdata(rdata1), .sram_addr(sa1), .sram_data(sd1),
    .sram_ceb(ceb1), .sram_rnw(rnw1), .sram_oeb(oeb1));

  // Behavioural async SRAMs: write while ce and we are low, drive while
  // ce and oe are low. Evaluated 2 time units after each edge.
  logic [7:0] mem0 [int];
  logic [7:0] mem1 [int];
  logic [7:0] rd0 = 0, rd1 = 0;
  assign sd0 = (!ceb0 && !oeb0 && rnw0) ? rd0 : 8'bz;
  assign sd1 = (!ceb1 && !oeb1 && rnw1) ? rd1 : 8'bz;
  always begin
    @(posedge clk); #2;
    if (!ceb0 && !rnw0) mem0[int'(sa0)] = sd0;
    if (!ceb1 && !rnw1) mem1[int'(sa1)] = sd1;
    rd0 = mem0.exists(int'(sa0)) ? mem0[int'(sa0)] : 8'h00;
    rd1 = mem1.exists(int'(sa1)) ? mem1[int'(sa1)] : 8'h00;
  end

  // Reference contents: what a client expects to read back.
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd = 8'h00;
  function automatic logic [7:0] refv(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-protocol monitor, one call per controller per cycle.
  task automatic mon(input string t, input logic ceb, rnw, oeb,
                     input logic [18:0] a, input logic [7:0] d, rdv,
                     inout logic prv_rd, prv_ce, inout logic [18:0] pa,
                     inout logic [7:0] pd);
    chk({t, "_rnw_with_oe"}, 32'(!rnw && !oeb), 0);
    if (!oeb) chk({t, "_contention"}, d, rdv);
    if (prv_rd) chk({t, "_turnaround"}, 32'(oeb && d !== 8'hFF), 0);
    if (!ceb && prv_ce) begin
      chk({t, "_addr_hold"}, a, pa);
      if (oeb) chk({t, "_data_hold"}, d, pd);
    end
    prv_rd = !oeb;
    prv_ce = !ceb;
    pa = a;
    pd = d;
  endtask

  logic        m0_rd = 0, m0_ce = 0, m1_rd = 0, m1_ce = 0;
  logic [18:0] m0_a = 0, m1_a = 0;
  logic [7:0]  m0_d = 0, m1_d = 0;
  always @(negedge clk) begin
    if (!reset) begin
      mon("u0", ceb0, rnw0, oeb0, sa0, sd0, rd0, m0_rd, m0_ce, m0_a, m0_d);
      mon("u1", ceb1, rnw1, oeb1, sa1, sd1, rd1, m1_rd, m1_ce, m1_a, m1_d);
    end else begin
      m0_rd = 0; m0_ce = 0; m1_rd = 0; m1_ce = 0;
    end
  end

  int acc_cnt0 = 0, ack_cnt0 = 0;
  always @(posedge clk) if (!reset && !busy0 && req0) acc_cnt0 <= acc_cnt0 + 1;
  always @(negedge clk) if (ack0) ack_cnt0 <= ack_cnt0 + 1;

  // One access on controller 0. inj>0 raises a spurious write request
  // for one cycle at that point in the access, which must be ignored.
  task automatic acc0(input string tag, input logic w, input logic [18:0] a,
                      input logic [7:0] d, input int inj);
    int rl, ds, k;
    bit got;
    @(posedge clk); #1;
    req0 = 1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 0; we0 = 1'($urandom); addr0 = 19'($urandom); wdata0 = 8'($urandom);
    rl = 0; ds = 0; k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (k == 1) chk({tag, "_busy_rise"}, busy0, 1);
      if (k == inj) begin req0 = 1; we0 = 1; addr0 = a ^ 19'h1; end
      if (k == inj + 1) req0 = 0;
      if (!rnw0) rl++;
      if (sd0 === d) ds++;
      if (ack0) got = 1;
    end
    chk({tag, "_ack_seen"}, got, 1);
    chk({tag, "_latency"}, k, w ? WR0 + 3 : RD0 + 2);
    chk({tag, "_busy_at_ack"}, busy0, 1);
    if (w) begin
      chk({tag, "_rnw_low_cycles"}, rl, WR0 + 1);
      chk({tag, "_drive_cycles"}, ds, WR0 + 3);
      chk({tag, "_rdata_held"}, rdata0, last_rd);
      ref_mem[int'(a)] = d;
    end else begin
      chk({tag, "_rdata"}, rdata0, refv(a));
      last_rd = refv(a);
    end
    @(negedge clk);
    chk({tag, "_busy_fall"}, busy0, 0);
    chk({tag, "_ack_fall"}, ack0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] pool [4];
    int last, prv;
    bit lastw, hit;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ceb", ceb0, 1);
    chk("rst_rnw", rnw0, 1);
    chk("rst_oeb", oeb0, 1);
    chk("rst_bus", sd0, 8'hFF);
    chk("rst_ack", ack0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_addr", sa0, 0);

    // basic write/read and address extremes
    acc0("wr_a5", 1, 19'h12345, 8'hA5, 0);
    acc0("rd_a5", 0, 19'h12345, 8'h00, 0);
    acc0("wr_top", 1, 19'h7FFFF, 8'h3C, 0);
    acc0("wr_zero", 1, 19'h00000, 8'hC3, 0);
    acc0("rd_top", 0, 19'h7FFFF, 8'h00, 0);
    acc0("rd_zero", 0, 19'h00000, 8'h00, 0);

    // requests while busy are dropped
    acc0("rd_inj", 0, 19'h12345, 8'h00, 1);
    acc0("wr_inj", 1, 19'h00100, 8'h5A, 2);
    acc0("rd_noinj_a", 0, 19'h12344, 8'h00, 0);
    acc0("rd_noinj_b", 0, 19'h00101, 8'h00, 0);
    @(posedge clk); @(negedge clk);
    chk("ack_eq_accept", ack_cnt0, acc_cnt0);

    // controller 1: req held high, alternating read/write
    @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 19'h00042; wdata1 = 8'h11;
    last = 0; lastw = 0;
    for (int i = 0; i < 8; i++) begin
      hit = 0;
      for (int w = 0; w < 20 && !hit; w++) begin
        @(negedge clk);
        if (!busy1) hit = 1;
      end
      chk("u1_accept_seen", hit, 1);
      if (i > 0) chk(lastw ? "u1_period_wr" : "u1_period_rd", cyc - last, lastw ? WR1 + 4 : RD1 + 3);
      last = cyc; lastw = we1;
      @(posedge clk); #1;
      we1 = ~we1; addr1 = 19'($urandom); wdata1 = 8'($urandom_range(0, 254));
    end
    req1 = 0;

    // random traffic on controller 0 over a small address pool
    pool[0] = 19'h7FFFF; pool[1] = 19'h00000;
    pool[2] = 19'($urandom); pool[3] = pool[2] ^ 19'h40000;
    for (int i = 0; i < 24; i++) begin
      prv = $urandom_range(0, 3);
      acc0($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), pool[prv],
           8'($urandom_range(0, 254)), 0);
    end

    // reset during second write-pulse cycle
    acc0("wr_99", 1, 19'h12346, 8'h99, 0);
    acc0("rd_99", 0, 19'h12346, 8'h00, 0);
    prv = ack_cnt0;
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 19'h55555; wdata0 = 8'h77;
    @(posedge clk); #1 req0 = 0;   // WSET
    @(posedge clk); #1;            // WPUL 1
    @(posedge clk); #1 reset = 1;  // WPUL 2
    @(negedge clk);
    chk("trunc_rnw_low", rnw0, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("trunc_ceb", ceb0, 1);
    chk("trunc_rnw", rnw0, 1);
    chk("trunc_oeb", oeb0, 1);
    chk("trunc_bus", sd0, 8'hFF);
    chk("trunc_busy", busy0, 0);
    chk("trunc_ack", ack0, 0);
    chk("trunc_rdata", rdata0, 0);
    @(negedge clk);
    chk("trunc_no_ack", ack_cnt0, prv);
    last_rd = 8'h00;
    acc0("rd_after_rst", 0, 19'h12346, 8'h00, 0);
    acc0("rd_top_after_rst", 0, 19'h7FFFF, 8'h00, 0);
    @(posedge clk); @(negedge clk);
    chk("ack_eq_accept_end", ack_cnt0, acc_cnt0 - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
